// File: rtl/mc_downsamp_ctrl.sv
// mc_downsamp_ctrl: multi-channel decimator with run-time factor/phase and a config-checking FSM.
// Optional macro DWSAMP_INTDUMP_EN selects integrate-and-dump instead of sample-pick.
`default_nettype none

module mc_downsamp_ctrl #(
  parameter int NCH        = 2,
  parameter int NBT_IN_OUT = 8,
  parameter int NBF_IN_OUT = 7,
  parameter int MAX_FACTOR = 8,
  parameter int NB_CFG     = 4
) (
  input  logic                      clk,
  input  logic                      i_reset,
  input  logic                      i_en,
  input  logic [NB_CFG-1:0]         i_factor,
  input  logic [NB_CFG-1:0]         i_phase,
  input  logic                      i_valid,
  input  logic [NCH*NBT_IN_OUT-1:0] i_data,
  output logic [NCH*NBT_IN_OUT-1:0] o_data,
  output logic                      o_valid,
  output logic                      o_locked,
  output logic                      o_cfg_err
);

  localparam int                NBD   = NCH * NBT_IN_OUT;
  localparam logic [NB_CFG-1:0] MAX_F = NB_CFG'(MAX_FACTOR);
  localparam logic [NB_CFG-1:0] ONE   = NB_CFG'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [NB_CFG-1:0] f_r;
  logic [NB_CFG-1:0] p_r;
  logic [NB_CFG-1:0] cnt;
  logic              cfg_ok;
  logic              cfg_chg;
  logic              accept;
  logic              cnt_last;
  wire               dump;
  wire  [NBD-1:0]    dump_data;

  // Parameter sets where the config width cannot hold MAX_FACTOR, or the format has no sign bit.
  generate
    if ((2 ** NB_CFG) <= MAX_FACTOR || NBF_IN_OUT >= NBT_IN_OUT) begin : g_bad_params
    end
  endgenerate

  always_comb begin
    cfg_ok   = (i_factor >= ONE) && (i_factor <= MAX_F) && (i_phase < i_factor);
    cfg_chg  = (i_factor != f_r) || (i_phase != p_r);
    cnt_last = (cnt == (f_r - ONE));
    accept   = (state == RUN) && i_en && cfg_ok && !cfg_chg && i_valid;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (i_en) state_nx = cfg_ok ? ALIGN : ERR;
      end
      ALIGN: state_nx = RUN;
      RUN: begin
        if (!i_en)        state_nx = IDLE;
        else if (!cfg_ok) state_nx = ERR;
        else if (cfg_chg) state_nx = ALIGN;
      end
      ERR: begin
        if (!i_en)       state_nx = IDLE;
        else if (cfg_ok) state_nx = ALIGN;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
      f_r   <= '0;
      p_r   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == ALIGN) begin
        f_r <= i_factor;
        p_r <= i_phase;
        cnt <= '0;
      end else if (accept) begin
        cnt <= cnt_last ? '0 : cnt + ONE;
      end
    end
  end

`ifdef DWSAMP_INTDUMP_EN
  localparam int NBA = NBT_IN_OUT + NB_CFG;

  assign dump = accept && cnt_last;

  genvar ch;
  generate
    for (ch = 0; ch < NCH; ch++) begin : g_ch
      logic        [NBT_IN_OUT-1:0] smp;
      logic signed [NBA-1:0]        acc;
      logic signed [NBA-1:0]        sum;
      logic        [NB_CFG:0]       hi;
      logic        [NBT_IN_OUT-1:0] sat;

      assign smp = i_data[ch*NBT_IN_OUT +: NBT_IN_OUT];
      assign sum = acc + {{NB_CFG{smp[NBT_IN_OUT-1]}}, smp};
      assign hi  = sum[NBA-1:NBT_IN_OUT-1];

      // Headroom bits all equal to the sign means the sum fits the output width.
      always_comb begin
        if ((&hi) || !(|hi)) sat = sum[NBT_IN_OUT-1:0];
        else if (sum[NBA-1]) sat = {1'b1, {(NBT_IN_OUT-1){1'b0}}};
        else                 sat = {1'b0, {(NBT_IN_OUT-1){1'b1}}};
      end

      assign dump_data[ch*NBT_IN_OUT +: NBT_IN_OUT] = sat;

      always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset)                     acc <= '0;
        else if (state != RUN || dump)    acc <= '0;
        else if (accept)                  acc <= sum;
      end
    end
  endgenerate
`else
  assign dump      = accept && (cnt == p_r);
  assign dump_data = i_data;
`endif

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= dump;
      if (dump) o_data <= dump_data;
    end
  end

  assign o_locked  = (state == RUN);
  assign o_cfg_err = (state == ERR);

endmodule

`default_nettype wire

// File: doc/mc_downsamp_ctrl.md
Name: mc_downsamp_ctrl

Overview:
Parametrised multi-channel decimator, successor to the fixed rate-2 receiver downsampler. Sits after the anti-alias filters and feeds the FSE.
- Decimation factor and sampling phase are selectable at run time.
- Each sample carries an explicit valid strobe.
- Config changes and illegal settings are handled by a small control FSM.
- All channels (I, Q, …) share one counter, so they stay phase-aligned.

Parameters:
NCH, 2, number of channels packed on the data buses
NBT_IN_OUT, 8, total bits per channel sample
NBF_IN_OUT, 7, fractional bits per channel sample (informational; no rescaling)
MAX_FACTOR, 8, largest legal decimation factor
NB_CFG, 4, width of factor/phase config inputs; must satisfy 2^NB_CFG > MAX_FACTOR

Ports:
clk  input  1  system clock; everything on rising edge
i_reset  input  1  asynchronous active-low reset
i_en  input  1  block enable
i_factor  input  NB_CFG  decimation factor D, unsigned
i_phase  input  NB_CFG  sample index kept within each group of D, unsigned
i_valid  input  1  i_data holds a new sample this cycle
i_data  input  NCH*NBT_IN_OUT  packed signed samples, ch0 in LSBs
o_data  output  NCH*NBT_IN_OUT  packed decimated samples, registered
o_valid  output  1  one-cycle strobe, o_data updated this cycle
o_locked  output  1  FSM in RUN
o_cfg_err  output  1  FSM in ERR

Behaviour:
- Reset (i_reset=0, async): state=IDLE, cnt=0, latched cfg=0, o_data=0, o_valid=0, o_locked=0, o_cfg_err=0.
- Config is legal iff 1<=i_factor<=MAX_FACTOR and i_phase<i_factor.

FSM:
- IDLE: inputs ignored, o_valid=0. If i_en=1, go to ALIGN when config is legal, else to ERR.
- ALIGN: lasts exactly 1 cycle. Latches i_factor/i_phase into f_r/p_r and clears cnt. Any i_valid in this cycle is discarded. Next state is RUN.
- RUN: o_locked=1. Transitions, highest priority first:
  - i_en=0 → IDLE.
  - Config illegal → ERR.
  - (i_factor,i_phase) differs from (f_r,p_r) → ALIGN.
  - The change is seen the same cycle; a sample arriving on that cycle is discarded.
- ERR: o_cfg_err=1, o_valid=0. i_en=0 → IDLE; config becomes legal → ALIGN.

Sample selection (RUN only, on i_valid=1):
- If cnt==p_r, all NCH channels of i_data are captured into o_data and o_valid=1 on the next cycle. Latency is 1 clk from the accepted sample.
- cnt advances only on accepted samples; it wraps from f_r-1 to 0. With i_valid=0 it holds.
- f_r=1: every accepted sample is output; o_valid mirrors i_valid delayed 1 clk.
- Output is exactly one strobe per D accepted inputs, independent of gaps in i_valid.

Outputs across states:
- o_data holds its last value between strobes and across IDLE/ALIGN/ERR; it is cleared only by reset.
- o_valid is never asserted in a cycle following IDLE, ALIGN or ERR.
- An i_en deassertion mid-group abandons the partial group; re-enable restarts at cnt=0 via ALIGN.

Optional Feature:
Macro DWSAMP_INTDUMP_EN.
- Defined: each channel uses integrate-and-dump. An accumulator per channel, NBT_IN_OUT+NB_CFG bits signed, sums the D accepted samples of a group (cnt 0..f_r-1). At the sample where cnt wraps to 0, the sum is saturated to NBT_IN_OUT bits, keeping the same NBF, and emitted with o_valid 1 clk later. The result is a gain of D with no division. The accumulator is cleared in ALIGN, in IDLE and at each dump. p_r is latched and checked for legality but does not select the output instant.
- Undefined: pure sample-pick decimation as above, with no accumulators synthesised.

Test Plan:
- Default D=2, phase 0, i_valid=1 continuously, I ramp 0,1,2,… → ALIGN 1 cycle, then o_valid every 2nd cycle, I outputs 0,2,4,… delayed 1 clk, o_locked=1.
- D=4, phase 3, i_valid toggling 1/0, ramp on ch0 and negated ramp on ch1 → outputs (3,-3),(7,-7),… with one strobe per 4 accepted samples; both channels always aligned.
- In RUN, change phase 0→1 mid-group → one ALIGN cycle, cnt restarts at 0, and the sample arriving that cycle is dropped (no o_valid for it). The next strobe carries the 2nd accepted post-ALIGN sample.
- Set D=0, then D=9, then phase=D → o_cfg_err=1, o_valid=0, o_locked=0. Restoring D=2, phase=0 → ALIGN then RUN, o_cfg_err=0.
- Assert i_reset=0 asynchronously mid-RUN with o_data=0x55 → all outputs 0 immediately, without waiting for a clock edge. After release with i_en=1, first strobe appears 1 clk after the phase-matched sample.
- With DWSAMP_INTDUMP_EN: D=4, ch0 constant 0x30 (0.375 Q1.7) → sum 0xC0 saturates to 0x7F. Constant 0x08 → 0x20. Constant 0x80 → 0x80 (negative saturation).
